// File: rtl/npu_ahb_pkg.sv
// rtl/npu_ahb_pkg.sv - shared AHB-Lite encodings and write-master state type
// Purpose: constants shared by the stream-to-AHB write master and the SRAM
// bridge it feeds, plus the master's FSM state enum.
package npu_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_FLUSH = 3'd2,
        ST_ERR   = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/npu_stream_to_ahb.sv
// rtl/npu_stream_to_ahb.sv - valid/ready word stream to AHB-Lite incrementing writes
// Purpose: programmed with a byte base and a word count, writes each accepted
// stream word to consecutive word addresses on the AHB-Lite bus.
// Ports:
//   HCLK, HRESET            clock, asynchronous active-high reset
//   cfg_start/base/len      job start pulse, byte base address, word count
//   busy, done, error       job status (done is a one-cycle pulse, error sticky)
//   s_valid/s_data/s_ready  input word stream
//   HADDR..HWDATA           AHB-Lite master outputs
//   HREADY, HRESP           AHB-Lite slave responses
module npu_stream_to_ahb
    import npu_ahb_pkg::*;
#(
    parameter int AW = 16,
    parameter int LW = 12
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic          cfg_start,
    input  logic [AW-1:0] cfg_base,
    input  logic [LW-1:0] cfg_len,
    output logic          busy,
    output logic          done,
    output logic          error,
    input  logic          s_valid,
    input  logic [31:0]   s_data,
    output logic          s_ready,
    output logic [AW-1:0] HADDR,
    output logic [1:0]    HTRANS,
    output logic          HWRITE,
    output logic [2:0]    HSIZE,
    output logic [2:0]    HBURST,
    output logic [31:0]   HWDATA,
    input  logic          HREADY,
    input  logic          HRESP
);

    state_e        state_q,  state_d;
    logic [AW-1:0] addr_q,   addr_d;    // address of the next beat to launch
    logic [LW-1:0] rem_q,    rem_d;     // beats not yet launched
    logic [AW-1:0] haddr_q,  haddr_d;
    logic [1:0]    htrans_q, htrans_d;
    logic [31:0]   wdata_q,  wdata_d;   // data belonging to the address phase on the bus
    logic [31:0]   hwdata_q, hwdata_d;
    logic          error_q,  error_d;
    logic          hs;

    // HRESP is excluded so no word is taken during either error-response cycle.
    assign s_ready = (state_q == ST_RUN) && HREADY && !HRESP && (rem_q != '0);
    assign hs      = s_ready && s_valid;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        haddr_d  = haddr_q;
        htrans_d = htrans_q;
        wdata_d  = wdata_q;
        hwdata_d = hwdata_q;
        error_d  = error_q;

        // An accepted address phase moves its data onto HWDATA for the data phase.
        if (HREADY && !HRESP && (htrans_q != HTRANS_IDLE)) begin
            hwdata_d = wdata_q;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    addr_d  = cfg_base & ~AW'(3);
                    rem_d   = cfg_len;
                    error_d = 1'b0;
                    state_d = (cfg_len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN, ST_FLUSH: begin
                if (HRESP && !HREADY) begin
                    // First error cycle: drop whatever address phase is pending.
                    htrans_d = HTRANS_IDLE;
                end else if (HRESP) begin
                    error_d  = 1'b1;
                    htrans_d = HTRANS_IDLE;
                    state_d  = ST_ERR;
                end else if (HREADY) begin
                    if (hs) begin
                        haddr_d  = addr_q;
                        // SEQ only continues an unbroken burst inside one 1KB page.
                        htrans_d = ((htrans_q == HTRANS_IDLE) || (addr_q[9:0] == 10'd0))
                                   ? HTRANS_NONSEQ : HTRANS_SEQ;
                        wdata_d  = s_data;
                        addr_d   = addr_q + AW'(4);
                        rem_d    = rem_q - LW'(1);
                        if (rem_q == LW'(1)) begin
                            state_d = ST_FLUSH;
                        end
                    end else begin
                        htrans_d = HTRANS_IDLE;
                    end
                    if (state_q == ST_FLUSH) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_ERR: begin
                htrans_d = HTRANS_IDLE;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            rem_q    <= '0;
            haddr_q  <= '0;
            htrans_q <= HTRANS_IDLE;
            wdata_q  <= '0;
            hwdata_q <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            haddr_q  <= haddr_d;
            htrans_q <= htrans_d;
            wdata_q  <= wdata_d;
            hwdata_q <= hwdata_d;
            error_q  <= error_d;
        end
    end

    assign busy   = (state_q == ST_RUN) || (state_q == ST_FLUSH) || (state_q == ST_ERR);
    assign done   = (state_q == ST_DONE);
    assign error  = error_q;
    assign HADDR  = haddr_q;
    assign HTRANS = htrans_q;
    assign HWRITE = 1'b1;
    assign HSIZE  = HSIZE_WORD;
    assign HBURST = HBURST_INCR;
    assign HWDATA = hwdata_q;

endmodule

// File: tb/tb_npu_stream_to_ahb.sv
// tb/tb_npu_stream_to_ahb.sv - self-checking bench for npu_stream_to_ahb
module tb_npu_stream_to_ahb;
    import npu_ahb_pkg::*;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        cfg_start;
    logic [15:0] cfg_base;
    logic [11:0] cfg_len;
    logic        busy, done, error;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;
    logic [15:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE, HBURST;
    logic [31:0] HWDATA;
    logic        HREADY, HRESP;

    npu_stream_to_ahb #(.AW(16), .LW(12)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .cfg_start(cfg_start), .cfg_base(cfg_base), .cfg_len(cfg_len),
        .busy(busy), .done(done), .error(error),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Job configuration (written by the stimulus process only)
    logic [31:0] words [64];
    int          nwords  = 0;
    int          vmode   = 0;   // 0 always valid, 1 random, 2 two-cycle stall after beat 1
    int          rmode   = 0;   // 0 zero wait, 1 random waits in data phases
    int          err_at  = -1;  // data-phase beat index that gets an ERROR response
    int          wait_at = -1;  // data-phase beat index that gets 3 wait states
    logic        drv_en  = 1'b0;
    logic [1:0]  exp_tr [$];

    // Monitor state (written by the monitor only)
    typedef struct {
        logic [15:0] addr;
        logic [1:0]  tr;
        logic        prev_idle;
        logic [31:0] data;
    } wr_t;
    wr_t         wr_q [$];
    logic [1:0]  tr_q [$];
    int          cyc = 0, start_cyc = 0, done_cyc = 0, last_hs_cyc = 0;
    int          hs_count = 0, comp_count = 0, done_cnt = 0, nonidle = 0;
    logic        data_pending = 1'b0, in_trace = 1'b0;
    logic [15:0] pend_addr;
    logic [1:0]  pend_tr;
    logic        pend_prev_idle;
    logic [1:0]  phase_prev = HTRANS_IDLE;
    logic        last_rst = 1'b1, last_hready = 1'b1, last_hresp = 1'b0, l_pend = 1'b0;
    logic [15:0] l_haddr;
    logic [1:0]  l_trans;
    logic [31:0] l_hwdata;

    always @(negedge HCLK) begin
        if (HRESET) begin
            last_rst     = 1'b1;
            data_pending = 1'b0;
            last_hready  = 1'b1;
            last_hresp   = 1'b0;
        end else begin
            logic pend_at_start;
            cyc++;
            if (cfg_start && !busy) begin
                wr_q.delete(); tr_q.delete();
                hs_count = 0; comp_count = 0; done_cnt = 0; nonidle = 0;
                in_trace = 1'b0; data_pending = 1'b0; start_cyc = cyc;
            end
            if (!last_rst) begin
                if (!last_hready && !last_hresp) begin
                    check_eq("hold_haddr", 32'(HADDR), 32'(l_haddr));
                    check_eq("hold_htrans", 32'(HTRANS), 32'(l_trans));
                    if (l_pend) check_eq("hold_hwdata", HWDATA, l_hwdata);
                end
                if (last_hresp && !last_hready) check_eq("err_cancel_idle", 32'(HTRANS), 32'(HTRANS_IDLE));
            end
            if (!HREADY) check_eq("sready_in_wait", 32'(s_ready), 32'd0);
            if (last_hready) phase_prev = l_trans;
            if (HTRANS != HTRANS_IDLE) begin in_trace = 1'b1; nonidle++; end
            if (in_trace) tr_q.push_back(HTRANS);
            if (s_valid && s_ready) begin hs_count++; last_hs_cyc = cyc; end
            pend_at_start = data_pending;
            if (HREADY && data_pending) begin
                if (!HRESP) wr_q.push_back('{pend_addr, pend_tr, pend_prev_idle, HWDATA});
                data_pending = 1'b0;
                comp_count++;
            end
            if (HREADY && !HRESP && HTRANS != HTRANS_IDLE) begin
                pend_addr      = HADDR;
                pend_tr        = HTRANS;
                pend_prev_idle = (phase_prev == HTRANS_IDLE);
                data_pending   = 1'b1;
            end
            if (done) begin done_cnt++; done_cyc = cyc; end
            l_haddr = HADDR; l_trans = HTRANS; l_hwdata = HWDATA; l_pend = pend_at_start;
            last_hready = HREADY; last_hresp = HRESP; last_rst = 1'b0;
        end
    end

    // Stream source and AHB slave responses
    int stall_cnt = 0, wait_cnt = 0, err_state = 0;
    always @(posedge HCLK) begin
        #1;
        if (!drv_en) begin
            s_valid = 1'b0; HREADY = 1'b1; HRESP = 1'b0;
            stall_cnt = 0; wait_cnt = 0; err_state = 0;
        end else begin
            logic v;
            case (vmode)
                1:       v = ($urandom_range(0, 2) != 0);
                2: begin v = !(hs_count == 1 && stall_cnt < 2); if (!v) stall_cnt++; end
                default: v = 1'b1;
            endcase
            s_valid = v && (hs_count < nwords);
            s_data  = words[hs_count % 64];
            if (err_state == 1) begin
                HREADY = 1'b1; HRESP = 1'b1; err_state = 2;
            end else if (data_pending && comp_count == err_at && err_state == 0) begin
                HREADY = 1'b0; HRESP = 1'b1; err_state = 1;
            end else begin
                HRESP = 1'b0;
                if (data_pending && comp_count == wait_at && wait_cnt < 3) begin
                    HREADY = 1'b0; wait_cnt++;
                end else if (data_pending && rmode == 1) HREADY = ($urandom_range(0, 2) != 0);
                else HREADY = 1'b1;
            end
        end
    end

    // lat_mode: 1 = done two cycles after last handshake, 2 = done one cycle after start
    task automatic run_job(input logic [15:0] base, input int len, input int nw, input int vm,
                           input int rm, input int ea, input int wa, input int exp_cons,
                           input int lat_mode);
        logic [15:0] abase;
        int          n_exp;
        @(posedge HCLK); #3;
        drv_en = 1'b0;
        nwords = nw; vmode = vm; rmode = rm; err_at = ea; wait_at = wa;
        for (int i = 0; i < 64; i++) words[i] = $urandom;
        @(posedge HCLK); #3;
        cfg_base = base; cfg_len = 12'(len); cfg_start = 1'b1; drv_en = 1'b1;
        @(posedge HCLK); #3;
        cfg_start = 1'b0;
        for (int k = 0; k < 2000 && done_cnt == 0; k++) @(posedge HCLK);
        repeat (4) @(posedge HCLK);
        #3;
        check_eq("done_once", 32'(done_cnt), 32'd1);
        check_eq("busy_end", 32'(busy), 32'd0);
        check_eq("error_flag", 32'(error), (ea >= 0) ? 32'd1 : 32'd0);
        n_exp = (ea >= 0) ? ea : len;
        abase = base & 16'hFFFC;
        check_eq("beats", 32'(wr_q.size()), 32'(n_exp));
        for (int i = 0; i < n_exp && i < wr_q.size(); i++) begin
            logic [15:0] ea16;
            logic [1:0]  et;
            ea16 = abase + 16'(4 * i);
            et   = (i == 0 || wr_q[i].prev_idle || ea16[9:0] == 10'd0) ? HTRANS_NONSEQ : HTRANS_SEQ;
            check_eq($sformatf("addr[%0d]", i), 32'(wr_q[i].addr), 32'(ea16));
            check_eq($sformatf("data[%0d]", i), wr_q[i].data, words[i]);
            check_eq($sformatf("htrans[%0d]", i), 32'(wr_q[i].tr), 32'(et));
        end
        check_eq("consumed", 32'(hs_count), (exp_cons >= 0) ? 32'(exp_cons) : 32'(len));
        for (int i = 0; i < exp_tr.size(); i++)
            check_eq($sformatf("trace[%0d]", i), (i < tr_q.size()) ? 32'(tr_q[i]) : 32'hDEAD, 32'(exp_tr[i]));
        if (lat_mode == 1) check_eq("done_latency", 32'(done_cyc - last_hs_cyc), 32'd2);
        if (lat_mode == 2) begin
            check_eq("done_latency0", 32'(done_cyc - start_cyc), 32'd1);
            check_eq("nonidle_len0", 32'(nonidle), 32'd0);
        end
        exp_tr.delete();
        drv_en = 1'b0;
    endtask

    initial begin
        HRESET = 1'b1; cfg_start = 1'b0; cfg_base = '0; cfg_len = '0;
        s_valid = 1'b0; s_data = '0; HREADY = 1'b1; HRESP = 1'b0;
        repeat (3) @(posedge HCLK);
        #3;
        check_eq("rst_htrans", 32'(HTRANS), 32'(HTRANS_IDLE));
        check_eq("rst_haddr", 32'(HADDR), 32'd0);
        check_eq("rst_status", {29'd0, busy, done, error}, 32'd0);
        check_eq("rst_sready", 32'(s_ready), 32'd0);
        check_eq("tie_ctrl", {25'd0, HWRITE, HSIZE, HBURST}, {25'd0, 1'b1, 3'b010, 3'b001});
        HRESET = 1'b0;

        exp_tr = '{HTRANS_NONSEQ, HTRANS_SEQ, HTRANS_SEQ, HTRANS_SEQ};
        run_job(16'h0100, 4, 4, 0, 0, -1, -1, -1, 1);
        exp_tr = '{HTRANS_NONSEQ, HTRANS_IDLE, HTRANS_IDLE, HTRANS_NONSEQ, HTRANS_SEQ};
        run_job(16'h0200, 3, 3, 2, 0, -1, -1, -1, 0);
        exp_tr = '{HTRANS_NONSEQ, HTRANS_SEQ, HTRANS_NONSEQ, HTRANS_SEQ};
        run_job(16'h03F8, 4, 4, 0, 0, -1, -1, -1, 0);
        exp_tr = '{HTRANS_NONSEQ, HTRANS_SEQ, HTRANS_NONSEQ, HTRANS_SEQ};
        run_job(16'hFFFB, 4, 4, 0, 0, -1, -1, -1, 0);
        run_job(16'h1000, 6, 6, 0, 0, -1, 1, -1, 0);
        run_job(16'h2000, 8, 8, 0, 0, 2, -1, 4, 0);
        run_job(16'h2100, 5, 5, 0, 0, -1, -1, -1, 0);
        run_job(16'h3000, 0, 0, 0, 0, -1, -1, -1, 2);
        for (int j = 0; j < 8; j++) begin
            logic [15:0] b;
            int          l;
            b = 16'($urandom);
            if (j % 3 == 0) b = {6'($urandom), 10'h3E0} | 16'($urandom_range(0, 31));
            l = $urandom_range(1, 24);
            run_job(b, l, l, 1, 1, -1, -1, -1, 0);
        end

        // Reset in the middle of a burst
        @(posedge HCLK); #3;
        nwords = 16; vmode = 0; rmode = 0; err_at = -1; wait_at = -1;
        @(posedge HCLK); #3;
        cfg_base = 16'h4000; cfg_len = 12'd16; cfg_start = 1'b1; drv_en = 1'b1;
        @(posedge HCLK); #3;
        cfg_start = 1'b0;
        for (int k = 0; k < 200 && hs_count < 3; k++) @(posedge HCLK);
        check_eq("rst_midburst_reached", 32'(hs_count >= 3), 32'd1);
        #4;
        HRESET = 1'b1;
        #1;
        check_eq("mid_rst_htrans", 32'(HTRANS), 32'(HTRANS_IDLE));
        check_eq("mid_rst_haddr", 32'(HADDR), 32'd0);
        check_eq("mid_rst_hwdata", HWDATA, 32'd0);
        check_eq("mid_rst_status", {28'd0, s_ready, busy, done, error}, 32'd0);
        @(posedge HCLK); #3;
        drv_en = 1'b0;
        repeat (2) @(posedge HCLK);
        #3;
        HRESET = 1'b0;
        repeat (10) @(posedge HCLK);
        #3;
        check_eq("no_done_after_rst", 32'(done_cnt), 32'd0);
        check_eq("idle_after_rst", {30'd0, busy, 32'(HTRANS) != 0}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
